fifo_2p_ram_ctrl: RTL and testbench
===================================

FIFO_2P_RAM_CTRL -- requirements
Module: fifo_2p_ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM depth = 2**ADDR_WIDTH.
REQ-003 Parameter LATENCY, default 3, RAM pipeline latency, min 2.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid/in_ready/in_data  in/out/in  1/1/DATA_WIDTH  upstream ready-valid push.
REQ-007 out_valid/out_ready/out_data  out/in/out  1/1/DATA_WIDTH  downstream ready-valid pop.
REQ-008 ram_write_enable/ram_write_addr/ram_data_in  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port drive.
REQ-009 ram_read_enable/ram_read_addr  out  1/ADDR_WIDTH  RAM read port drive.
REQ-010 ram_data_out  in  DATA_WIDTH  RAM read data, valid LATENCY-1 cycles after read issue.
REQ-011 count  out  ADDR_WIDTH+3  total words held (RAM + in-flight + output buffer).

Function
REQ-012 Push accepted on edge where in_valid && in_ready; same cycle ram_write_enable=1, ram_write_addr=wr_ptr, ram_data_in=in_data (combinational); wr_ptr increments, wraps 2**ADDR_WIDTH-1 -> 0.
REQ-013 in_ready = (ram_used < 2**ADDR_WIDTH), ram_used = accepted minus read-issued; no dependence on in_valid.
REQ-014 Written entry becomes read-eligible LATENCY+1 edges after acceptance; tracked by (LATENCY+1)-deep commit shift register, never by address compare.
REQ-015 Read issue when committed-unread > 0 and (inflight + obuf_count) <= LATENCY; ram_read_enable=1, ram_read_addr=rd_ptr; rd_ptr increments with wrap.
REQ-016 RAM slot freed at read-issue edge; simultaneous accept and issue leave ram_used unchanged.
REQ-017 Read valid tracked by (LATENCY-1)-deep shift register; ram_data_out captured into output buffer on edge where tail stage is set.
REQ-018 Output buffer depth LATENCY+1, FIFO order; out_valid = buffer non-empty; out_data = registered head; never overflows by REQ-015.
REQ-019 No combinational path out_ready -> ram_read_enable or in_ready.
REQ-020 First-word latency: word accepted at edge E gives out_valid=1 after edge E+2*LATENCY (6 for LATENCY=3).
REQ-021 Steady state with in_valid=out_ready=1: one word per cycle, no bubbles.
REQ-022 Capacity: 2**ADDR_WIDTH + LATENCY+1 words (20 at defaults); count saturates there with in_ready=0.
REQ-023 Simultaneous push and pop: count unchanged; order strictly preserved across pointer wrap.

Reset
REQ-024 On rst: wr_ptr, rd_ptr, ram_used, commit/valid shift registers, output buffer, count = 0; out_valid=0, ram_write_enable=0, ram_read_enable=0, in_ready=1 after release.
REQ-025 Reset mid-operation: in-flight read data discarded; stale RAM writes land earlier than any post-reset write to the same address, so no stale word is ever output.

Structure
REQ-026 Package fifo_2p_ram_pkg holds default DATA_WIDTH/ADDR_WIDTH/LATENCY constants and OBUF_DEPTH = LATENCY+1 function.
REQ-027 One sub-module fifo_2p_ram_obuf (small register FIFO, depth OBUF_DEPTH); RAM instantiated outside this block.

Verification (defaults, bench RAM = simple_dual_port_RAM)
REQ-028 Reset -> out_valid=0, count=0, in_ready=1, ram enables 0.
REQ-029 Push 0xA5 once, out_ready=1 -> out_valid after 6 edges, out_data=0xA5, count 1 -> 0 on pop.
REQ-030 out_ready=0, push 0x00..0x17 continuously -> exactly 20 accepted, in_ready=0, count=20; then out_ready=1 -> 0x00..0x13 in order.
REQ-031 100 words stream, both sides always ready -> after initial latency one word per cycle, data matches.
REQ-032 40 words, random in_valid/out_ready -> pointers wrap twice, order and data exact, count never exceeds 20.
REQ-033 5 words pushed, rst one cycle mid-stream -> count=0, out_valid=0; next push 0x3C emerges alone after 6 edges.

Source files
------------

// File: rtl/fifo_2p_ram_pkg.sv
// Shared defaults and sizing helpers for the two-port-RAM FIFO controller.
package fifo_2p_ram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_LATENCY    = 3;

  // The output buffer must absorb every read that can be in flight plus one
  // word being held while downstream stalls.
  function automatic int obuf_depth(input int latency);
    return latency + 1;
  endfunction

endpackage

// File: rtl/fifo_2p_ram_obuf.sv
// Small register FIFO that catches RAM read data and presents it downstream.
module fifo_2p_ram_obuf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic [CW-1:0]         cnt_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Pointer advance with wrap for depths that are not a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i) wr_ptr_d = ptr_next(wr_ptr_q);
    if (rd_en_i) rd_ptr_d = ptr_next(rd_ptr_q);
    cnt_d = cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
  end

  // Control state; reset empties the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage is not reset; validity is carried by the count.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/fifo_2p_ram_ctrl.sv
// FIFO controller around an external simple dual-port RAM with pipelined reads.
module fifo_2p_ram_ctrl
  import fifo_2p_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_enable,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH+2:0] count
);

  localparam int CW     = ADDR_WIDTH + 3;
  localparam int OBUF_D = obuf_depth(LATENCY);
  localparam int OCW    = $clog2(OBUF_D + 1);
  localparam logic [CW-1:0] RAM_DEPTH_C = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] LAT_C       = CW'(LATENCY);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_used_q, ram_used_d;
  logic [CW-1:0]         avail_q, avail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [LATENCY:0]      commit_q, commit_d;
  logic [LATENCY-2:0]    rvld_q, rvld_d;

  logic                  push, issue, pop, capture, eligible;
  logic [CW-1:0]         inflight, obuf_cnt_ext;
  logic [OCW-1:0]        obuf_cnt;
  logic                  obuf_empty;

  // Number of reads currently travelling through the RAM pipeline.
  function automatic logic [CW-1:0] popcnt(input logic [LATENCY-2:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < LATENCY - 1; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Write side: accept whenever a RAM slot is free, write straight through.
  assign in_ready         = (ram_used_q < RAM_DEPTH_C);
  assign push             = in_valid && in_ready;
  assign ram_write_enable = push;
  assign ram_write_addr   = wr_ptr_q;
  assign ram_data_in      = in_data;

  // Read side: only registered state decides issue, so out_ready never
  // reaches the RAM read port or in_ready combinationally. The commit tail is
  // looked at directly so a word becomes readable the cycle it matures.
  assign inflight        = popcnt(rvld_q);
  assign obuf_cnt_ext    = CW'(obuf_cnt);
  assign eligible        = (avail_q != '0) || commit_q[LATENCY];
  assign issue           = eligible && ((inflight + obuf_cnt_ext) <= LAT_C);
  assign ram_read_enable = issue;
  assign ram_read_addr   = rd_ptr_q;
  assign capture         = rvld_q[LATENCY-2];

  assign out_valid = !obuf_empty;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Next-state for pointers, occupancy counters and the tracking shift registers.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(issue);
    ram_used_d = ram_used_q + CW'(push) - CW'(issue);
    avail_d    = avail_q + CW'(commit_q[LATENCY]) - CW'(issue);
    count_d    = count_q + CW'(push) - CW'(pop);
    commit_d    = '0;
    commit_d[0] = push;
    for (int i = 1; i <= LATENCY; i++) commit_d[i] = commit_q[i-1];
    rvld_d    = '0;
    rvld_d[0] = issue;
    for (int i = 1; i < LATENCY - 1; i++) rvld_d[i] = rvld_q[i-1];
  end

  // Control registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_used_q <= '0;
      avail_q    <= '0;
      count_q    <= '0;
      commit_q   <= '0;
      rvld_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_used_q <= ram_used_d;
      avail_q    <= avail_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      rvld_q     <= rvld_d;
    end
  end

  fifo_2p_ram_obuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_D)
  ) u_obuf (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (capture),
    .wr_data_i (ram_data_out),
    .rd_en_i   (pop),
    .rd_data_o (out_data),
    .empty_o   (obuf_empty),
    .cnt_o     (obuf_cnt)
  );

endmodule

// File: tb/tb_fifo_2p_ram_ctrl.sv
// Scoreboard bench for fifo_2p_ram_ctrl with a behavioural latency-3 RAM.
module tb_fifo_2p_ram_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_write_enable;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_enable;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_out;
  logic [AW+2:0] count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_pop = -1;
  int last_pop  = -1;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  fifo_2p_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .ram_write_enable (ram_write_enable),
    .ram_write_addr   (ram_write_addr),
    .ram_data_in      (ram_data_in),
    .ram_read_enable  (ram_read_enable),
    .ram_read_addr    (ram_read_addr),
    .ram_data_out     (ram_data_out),
    .count            (count)
  );

  // Simple dual-port RAM: write on edge, read data valid LAT-1 cycles after issue.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_p [LAT-1];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_data_in;
    if (ram_read_enable) rd_p[0] <= mem[ram_read_addr];
    for (int i = 1; i < LAT - 1; i++) rd_p[i] <= rd_p[i-1];
  end
  assign ram_data_out = rd_p[LAT-2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check count against the model, score the pop, log the push.
  task automatic step();
    logic [DW-1:0] e;
    #1;
    check_val("count", 32'(count), 32'(sb_q.size()));
    if (out_valid && out_ready) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (sb_q.size() == 0) check_val("spurious_pop", 32'(out_data), 32'hFFFF_FFFF);
      else begin
        e = sb_q.pop_front();
        check_val("data", 32'(out_data), 32'(e));
      end
    end
    if (in_valid && in_ready) sb_q.push_back(in_data);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Push one word into an empty FIFO and time its arrival.
  task automatic single_word(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    out_ready = 1'b1;
    #1;
    check_val("sw_in_ready", 32'(in_ready), 32'd1);
    check_val("sw_wen", 32'(ram_write_enable), 32'd1);
    check_val("sw_waddr", 32'(ram_write_addr), 32'd0);
    check_val("sw_wdata", 32'(ram_data_in), 32'(d));
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 2 * LAT; k++) begin
      step();
      check_val("sw_latency", 32'(out_valid), 32'(k == 2 * LAT));
    end
    check_val("sw_count1", 32'(count), 32'd1);
    step();
    check_val("sw_count0", 32'(count), 32'd0);
    for (int k = 0; k < 8; k++) begin
      check_val("sw_no_stale", 32'(out_valid), 32'd0);
      step();
    end
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb_q.size() > 0; i++) step();
    check_val("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int nxt;
    int sent;
    int maxc;
    logic acc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_wen", 32'(ram_write_enable), 32'd0);
    check_val("rst_ren", 32'(ram_read_enable), 32'd0);

    // Single word latency
    single_word(8'hA5);

    // Fill to capacity with the output stalled, then drain in order
    out_ready = 1'b0;
    nxt = 0;
    for (int i = 0; i < 60; i++) begin
      in_valid = (nxt < 24);
      in_data  = 8'(nxt);
      #1;
      acc = in_valid && in_ready;
      step();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    #1;
    check_val("fill_accepted", 32'(nxt), 32'd20);
    check_val("fill_in_ready", 32'(in_ready), 32'd0);
    check_val("fill_count", 32'(count), 32'd20);
    drain(200);

    // Full-rate stream: no bubbles once the first word appears
    first_pop = -1;
    sent = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 400 && (sent < 100 || sb_q.size() > 0); i++) begin
      in_valid = (sent < 100);
      in_data  = 8'($urandom);
      #1;
      if (in_valid) check_val("stream_in_ready", 32'(in_ready), 32'd1);
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    check_val("stream_sent", 32'(sent), 32'd100);
    check_val("stream_no_bubble", 32'(last_pop - first_pop), 32'd99);
    drain(50);

    // Random handshakes across several pointer wraps
    sent = 0;
    maxc = 0;
    for (int i = 0; i < 2000 && (sent < 40 || sb_q.size() > 0); i++) begin
      in_valid  = (sent < 40) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0) || (sent >= 40);
      #1;
      acc = in_valid && in_ready;
      if (int'(count) > maxc) maxc = int'(count);
      step();
      if (acc) sent++;
    end
    check_val("rand_sent", 32'(sent), 32'd40);
    check_val("rand_max_count", 32'(maxc <= 20), 32'd1);
    drain(100);

    // Reset with reads in flight
    out_ready = 1'b0;
    sent = 0;
    for (int i = 0; i < 20 && sent < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + sent);
      #1;
      acc = in_ready;
      step();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check_val("mid_rst_count", 32'(count), 32'd0);
    check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
    single_word(8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
